// File: rtl/keccak_pkg.sv
// Shared Keccak types and helpers for the digest output path.
`timescale 1ns/1ps

package keccak_pkg;

  localparam int LANE_W = 64;
  localparam int STATE_DIM = 5;
  localparam int DIGEST_MAX_WORDS = 8;

  typedef logic [0:4][0:4][LANE_W-1:0] keccak_state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'b00,
    SHA3_256 = 2'b01,
    SHA3_384 = 2'b10,
    SHA3_512 = 2'b11
  } sha3_mode_e;

  // Lanes streamed per digest; 224 uses four lanes with a half-filled tail.
  function automatic logic [3:0] mode_nwords(input sha3_mode_e m);
    logic [3:0] n;
    case (m)
      SHA3_224: n = 4'd4;
      SHA3_256: n = 4'd4;
      SHA3_384: n = 4'd6;
      default:  n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[56-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_digest_tx.sv
// Captures the final Keccak state and streams the SHA3 digest lanes as 64-bit words.
// Define KECCAK_DIGEST_BSWAP_EN to byte-reverse each lane so the first digest byte is out_data[63:56].
`timescale 1ns/1ps

module keccak_digest_tx
  import keccak_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_WORDS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            st_valid,
  input  logic [0:4][0:4][WIDTH-1:0]      st_in,
  output logic                            st_ready,
  input  logic [1:0]                      mode,
  output logic [63:0]                     out_data,
  output logic [7:0]                      out_keep,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy
);

  if (WIDTH != LANE_W) begin : g_width_check
    $error("keccak_digest_tx: only WIDTH=64 is supported");
  end
  if (MAX_WORDS != DIGEST_MAX_WORDS) begin : g_depth_check
    $error("keccak_digest_tx: MAX_WORDS must be 8");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                           state_q, state_d;
  logic [2:0]                       cnt_q, cnt_d;
  logic [3:0]                       nwords_q, nwords_d;
  sha3_mode_e                       mode_q, mode_d;
  logic [MAX_WORDS-1:0][WIDTH-1:0]  word_q, word_d;

  logic [MAX_WORDS-1:0][WIDTH-1:0]  cap_lane;
  logic [63:0]                      lane_out;
  logic [63:0]                      keep_mask;
  logic                             is_last;
  logic                             tail_224;
  logic                             unused_st_in;

  // Digest lane i sits at x = i % 5, y = i / 5 in the state array.
  for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_lane
    assign cap_lane[gi] = st_in[gi % STATE_DIM][gi / STATE_DIM];
  end

  // Lanes beyond the eighth are never part of a digest.
  assign unused_st_in = ^st_in;

`ifdef KECCAK_DIGEST_BSWAP_EN
  localparam logic [7:0] TAIL_KEEP = 8'hF0;
  assign lane_out = bswap64(word_q[cnt_q]);
`else
  localparam logic [7:0] TAIL_KEEP = 8'h0F;
  assign lane_out = word_q[cnt_q];
`endif

  assign is_last  = (state_q == ST_SEND) && ({1'b0, cnt_q} == (nwords_q - 4'd1));
  assign tail_224 = is_last && (mode_q == SHA3_224);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nwords_d = nwords_q;
    mode_d   = mode_q;
    word_d   = word_q;
    case (state_q)
      ST_IDLE: begin
        if (st_valid) begin
          word_d   = cap_lane;
          mode_d   = sha3_mode_e'(mode);
          nwords_d = mode_nwords(sha3_mode_e'(mode));
          cnt_d    = 3'd0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (is_last) begin
            cnt_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      nwords_q <= 4'd0;
      mode_q   <= SHA3_224;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nwords_q <= nwords_d;
      mode_q   <= mode_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    out_keep = 8'h00;
    if (state_q == ST_SEND) begin
      out_keep = tail_224 ? TAIL_KEEP : 8'hFF;
    end
  end

  // Unused bytes of a truncated word are forced to zero; idle output is all-zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_keep_mask
    assign keep_mask[8*gi +: 8] = {8{out_keep[gi]}};
  end

  assign out_data  = lane_out & keep_mask;
  assign out_valid = (state_q == ST_SEND);
  assign out_last  = is_last;
  assign busy      = (state_q == ST_SEND);
  assign st_ready  = (state_q == ST_IDLE) && !rst;

endmodule

// File: tb/tb_keccak_digest_tx.sv
// Scoreboard bench for keccak_digest_tx: byte-level SHA3 digest model feeding an expected-word queue.
`timescale 1ns/1ps

module tb_keccak_digest_tx;
  import keccak_pkg::*;

  typedef logic [0:4][0:4][63:0] st_t;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  st_t         st_in = '0;
  logic [1:0]  mode = 2'b00;
  logic        out_ready = 1'b0;
  logic        st_ready, out_valid, out_last, busy;
  logic [63:0] out_data;
  logic [7:0]  out_keep;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cap_cyc = -100;
  int words_seen = 0;
  bit force_rdy = 1'b1;
  exp_t exp_q[$];

  keccak_digest_tx #(.WIDTH(64), .MAX_WORDS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_in     (st_in),
    .st_ready  (st_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Digest = state bytes in lane order (little-endian within a lane), truncated to the mode length.
  function automatic void push_exp(input st_t s, input logic [1:0] m);
    byte unsigned dig[$];
    int nbytes, nw, idx, lane;
    exp_t e;
    nbytes = (m == 2'b00) ? 28 : (m == 2'b01) ? 32 : (m == 2'b10) ? 48 : 64;
    for (int b = 0; b < nbytes; b++) begin
      lane = b / 8;
      dig.push_back(s[lane % 5][lane / 5][8*(b % 8) +: 8]);
    end
    nw = (nbytes + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      e.keep = '0;
      for (int k = 0; k < 8; k++) begin
        idx = 8*w + k;
        if (idx < nbytes) begin
`ifdef KECCAK_DIGEST_BSWAP_EN
          e.data[63-8*k -: 8] = dig[idx];
          e.keep[7-k] = 1'b1;
`else
          e.data[8*k +: 8] = dig[idx];
          e.keep[k] = 1'b1;
`endif
        end
      end
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // Monitor: drives out_ready, pops and compares on each handshake.
  initial begin : monitor
    bit          held = 1'b0;
    bit          prev_valid = 1'b0;
    bit          rdy_next = 1'b0;
    logic [63:0] h_data;
    logic [7:0]  h_keep;
    logic        h_last;
    exp_t        e;
    forever begin
      @(negedge clk);
      out_ready = force_rdy ? 1'b1 : ($urandom_range(0, 2) != 0);
      #2;
      if (rst) begin
        held = 1'b0;
        prev_valid = 1'b0;
        rdy_next = 1'b0;
      end else begin
        if (rdy_next) chk("st_ready_after_last", st_ready, 1'b1);
        rdy_next = 1'b0;
        chk("busy_vs_valid", busy, out_valid);
        if (held) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, h_data);
          chk("stall_keep", out_keep, h_keep);
          chk("stall_last", out_last, h_last);
        end
        if (out_valid && !prev_valid) chk("capture_latency", cyc, last_cap_cyc + 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got data=%h required no word", out_data);
          end else begin
            e = exp_q.pop_front();
            $display("word %0d data=%h keep=%h last=%0b", words_seen, out_data, out_keep, out_last);
            chk("word_data", out_data, e.data);
            chk("word_keep", out_keep, e.keep);
            chk("word_last", out_last, e.last);
            if (e.last) rdy_next = 1'b1;
          end
          words_seen++;
        end
        held = out_valid && !out_ready;
        h_data = out_data;
        h_keep = out_keep;
        h_last = out_last;
        prev_valid = out_valid;
      end
    end
  end

  task automatic do_capture(input st_t s, input logic [1:0] m);
    int guard = 0;
    @(negedge clk);
    st_in = s;
    mode = m;
    st_valid = 1'b1;
    #1;
    while (!st_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("capture_ready", st_ready, 1'b1);
    if (st_ready) begin
      push_exp(s, m);
      last_cap_cyc = cyc;
    end
    @(negedge clk);
    st_valid = 1'b0;
    st_in = rand_state();
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      #3;
      g++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", out_valid, 1'b0);
  endtask

  task automatic random_run(input int ncyc, input int hold_pct);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      st_in = rand_state();
      mode = 2'($urandom_range(0, 3));
      st_valid = ($urandom_range(0, 99) < hold_pct);
      #1;
      if (st_valid && st_ready) begin
        push_exp(st_in, mode);
        last_cap_cyc = cyc;
      end
    end
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    st_t s1, s2, s3;
    int  base, g;

    s1 = '0;
    s1[0][0] = 64'h0123456789ABCDEF;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        s2[x][y] = 64'hA3A3A3A3A3A3A3A3;
        s3[x][y] = {8{4'(x), 4'(y)}};
      end

    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_keep", out_keep, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_st_ready", st_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("idle_st_ready", st_ready, 1'b1);

    force_rdy = 1'b1;
    do_capture(s1, 2'b01);
    drain();
    do_capture(s2, 2'b00);
    drain();

    // 512 ordering, with st_valid pulsed mid-stream that must be ignored.
    do_capture(s3, 2'b11);
    repeat (3) begin
      @(negedge clk);
      st_valid = 1'b1;
      st_in = rand_state();
      mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    st_valid = 1'b0;
    drain();

    // Reset after word1 of a 512 digest.
    base = words_seen;
    do_capture(s3, 2'b11);
    g = 0;
    while (words_seen < base + 2 && g < 50) begin
      @(negedge clk);
      #3;
      g++;
    end
    chk("midrst_words_before", words_seen, base + 2);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #3;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_last", out_last, 1'b0);
    chk("midrst_st_ready", st_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("postrst_st_ready", st_ready, 1'b1);
    do_capture(s1, 2'b01);
    drain();

    force_rdy = 1'b0;
    do_capture(s2, 2'b00);
    drain();
    random_run(800, 25);
    drain();
    random_run(80, 100);
    drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
